// File: rtl/fast_div.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, valid/ready on both sides.
// Companion to the 4x4 table multiplier; divides a product-width dividend by an operand-width divisor.
module fast_div #(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               io_in_valid,
  output logic               io_in_ready,
  input  logic [WIDTH_A-1:0] io_in_dividend,
  input  logic [WIDTH_B-1:0] io_in_divisor,
  output logic               io_out_valid,
  input  logic               io_out_ready,
  output logic [WIDTH_A-1:0] io_out_quotient,
  output logic [WIDTH_B-1:0] io_out_remainder,
  output logic               io_out_div0
);

  localparam int CNT_W = (WIDTH_A > 1) ? $clog2(WIDTH_A) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH_A-1:0] quot_reg;
  logic [WIDTH_B:0]   rem_reg;
  logic [WIDTH_B-1:0] div_reg;
  logic               div0_reg;

  logic [WIDTH_A-1:0] out_quot_reg;
  logic [WIDTH_B-1:0] out_rem_reg;
  logic               out_div0_reg;

  // One extra bit beyond the partial remainder catches the borrow of the trial subtraction.
  logic [WIDTH_B+1:0] rem_wide;
  logic [WIDTH_B+1:0] trial_diff;
  logic               fits;
  logic [WIDTH_B:0]   rem_next;
  logic [WIDTH_A-1:0] quot_next;

  always_comb begin
    rem_wide   = {rem_reg, quot_reg[WIDTH_A-1]};
    trial_diff = rem_wide - {2'b00, div_reg};
    fits       = ~trial_diff[WIDTH_B+1];
    rem_next   = fits ? trial_diff[WIDTH_B:0] : rem_wide[WIDTH_B:0];
    quot_next  = {quot_reg[WIDTH_A-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      quot_reg     <= '0;
      rem_reg      <= '0;
      div_reg      <= '0;
      div0_reg     <= 1'b0;
      out_quot_reg <= '0;
      out_rem_reg  <= '0;
      out_div0_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (io_in_valid) begin
            quot_reg  <= io_in_dividend;
            div_reg   <= io_in_divisor;
            rem_reg   <= '0;
            cnt_reg   <= CNT_W'(WIDTH_A - 1);
            div0_reg  <= (io_in_divisor == '0);
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          quot_reg <= quot_next;
          rem_reg  <= rem_next;
          if (cnt_reg == '0) begin
            // Final bit is resolved on this edge, so the result registers load from the next-state values.
            out_quot_reg <= div0_reg ? '1 : quot_next;
            out_rem_reg  <= div0_reg ? '1 : rem_next[WIDTH_B-1:0];
            out_div0_reg <= div0_reg;
            state_reg    <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DONE: begin
          if (io_out_ready) begin
            out_quot_reg <= '0;
            out_rem_reg  <= '0;
            out_div0_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign io_in_ready      = (state_reg == IDLE);
  assign io_out_valid     = (state_reg == DONE);
  assign io_out_quotient  = out_quot_reg;
  assign io_out_remainder = out_rem_reg;
  assign io_out_div0      = out_div0_reg;

endmodule
